// File: rtl/mem_io_unit.sv
// Load/store stage: routes ALU-addressed accesses to a latency-configurable data RAM or to a small IO block.
// Optional ALIGN_CHECK_EN rejects word-misaligned RAM accesses and reports them on a sticky misalign_o.
module mem_io_unit #(
    parameter int         MEM_LATENCY = 2,
    parameter int         RAM_AW      = 14,
    parameter logic [5:0] IO_HIGH     = 6'h3C,
    parameter int         LED_W       = 16,
    parameter int         SW_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [31:0]       addr_i,
    input  logic [5:0]        addr_high_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    output logic [LED_W-1:0]  led_o,
    input  logic [SW_W-1:0]   switch_i
`ifdef ALIGN_CHECK_EN
    ,
    output logic              misalign_o
`endif
);

    typedef enum logic [1:0] {IDLE, RAM_ACC, IO_ACC, DONE} state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] cnt;
    logic       op_write_q;
    logic [3:0] io_off_q;
    logic       misaligned_q;
    logic       req;
    logic       io_sel;
    logic       accept;
    logic       lat_hit;
    logic       unused_addr_bits;

    assign req     = mem_read_i | mem_write_i;
    assign io_sel  = (addr_high_i == IO_HIGH);
    assign accept  = (state == IDLE) && req;
    assign lat_hit = (cnt == 3'(MEM_LATENCY));

`ifdef ALIGN_CHECK_EN
    assign unused_addr_bits = ^addr_i[31:RAM_AW+2];

    // A misaligned RAM access skips the strobe and completes on the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
            misalign_o   <= 1'b0;
        end else begin
            if (accept)
                misaligned_q <= !io_sel && (addr_i[1:0] != 2'b00);
            if (state == RAM_ACC && misaligned_q)
                misalign_o <= 1'b1;
        end
    end
`else
    assign unused_addr_bits = ^{addr_i[31:RAM_AW+2], addr_i[1:0]};
    assign misaligned_q     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = io_sel ? IO_ACC : RAM_ACC;
            RAM_ACC: if (misaligned_q || lat_hit) next_state = DONE;
            IO_ACC:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The RAM strobe lives only in the first RAM_ACC cycle, while cnt is still zero.
    always_comb begin
        busy_o   = (state == RAM_ACC) || (state == IO_ACC);
        done_o   = (state == DONE);
        ram_en_o = (state == RAM_ACC) && (cnt == 3'd0) && !misaligned_q;
        ram_we_o = ram_en_o && op_write_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            op_write_q  <= 1'b0;
            io_off_q    <= '0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            rdata_o     <= '0;
            led_o       <= '0;
        end else begin
            if (accept) begin
                op_write_q  <= mem_write_i;
                io_off_q    <= addr_i[7:4];
                ram_addr_o  <= addr_i[RAM_AW+1:2];
                ram_wdata_o <= wdata_i;
                cnt         <= '0;
            end else if (state == RAM_ACC) begin
                cnt <= cnt + 3'd1;
            end

            if (state == RAM_ACC && lat_hit && !misaligned_q && !op_write_q)
                rdata_o <= ram_rdata_i;

            // Offset 0 is the LED register, offset 1 the switches; everything else reads as zero.
            if (state == IO_ACC) begin
                case (io_off_q)
                    4'd0: begin
                        if (op_write_q)
                            led_o <= ram_wdata_o[LED_W-1:0];
                        else
                            rdata_o <= 32'(led_o);
                    end
                    4'd1: if (!op_write_q) rdata_o <= 32'(switch_i);
                    default: if (!op_write_q) rdata_o <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed bench for mem_io_unit: RAM model with fixed read latency plus a scoreboard of expected load results.
module tb_mem_io_unit;

    localparam int MEM_LATENCY = 2;
    localparam int RAM_AW      = 14;
    localparam int LED_W       = 16;
    localparam int SW_W        = 16;

    logic              clk;
    logic              rst_n;
    logic              mem_read_i;
    logic              mem_write_i;
    logic [31:0]       addr_i;
    logic [5:0]        addr_high_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              busy_o;
    logic              done_o;
    logic              ram_en_o;
    logic              ram_we_o;
    logic [RAM_AW-1:0] ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic [31:0]       ram_rdata_i;
    logic [LED_W-1:0]  led_o;
    logic [SW_W-1:0]   switch_i;
`ifdef ALIGN_CHECK_EN
    logic              misalign_o;
`endif

    int                checks = 0;
    int                errors = 0;
    int                strobe_total = 0;
    logic [RAM_AW-1:0] last_addr;
    logic              last_we;
    logic [31:0]       last_wdata;
    logic [31:0]       model_rdata;
    logic [31:0]       sb_q[$];

    logic [31:0]            ram_mem [0:(1<<RAM_AW)-1];
    logic [31:0]            data_pipe [0:MEM_LATENCY-1];
    logic [MEM_LATENCY-1:0] valid_pipe = '0;

    mem_io_unit #(
        .MEM_LATENCY(MEM_LATENCY),
        .RAM_AW     (RAM_AW),
        .IO_HIGH    (6'h3C),
        .LED_W      (LED_W),
        .SW_W       (SW_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read_i (mem_read_i),
        .mem_write_i(mem_write_i),
        .addr_i     (addr_i),
        .addr_high_i(addr_high_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i),
        .led_o      (led_o),
        .switch_i   (switch_i)
`ifdef ALIGN_CHECK_EN
        ,
        .misalign_o (misalign_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM samples at the edge after the strobe; data is valid for one cycle only, garbage otherwise.
    always @(posedge clk) begin
        if (ram_en_o === 1'b1 && ram_we_o === 1'b1)
            ram_mem[ram_addr_o] <= ram_wdata_o;
        data_pipe[0]  <= ram_mem[ram_addr_o];
        valid_pipe[0] <= (ram_en_o === 1'b1) && (ram_we_o === 1'b0);
        for (int i = 1; i < MEM_LATENCY; i++) begin
            data_pipe[i]  <= data_pipe[i-1];
            valid_pipe[i] <= valid_pipe[i-1];
        end
    end

    assign ram_rdata_i = valid_pipe[MEM_LATENCY-1] ? data_pipe[MEM_LATENCY-1] : 32'hBAD0_BAD0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ram_en_o === 1'b1) begin
            strobe_total++;
            last_addr  = ram_addr_o;
            last_we    = ram_we_o;
            last_wdata = ram_wdata_o;
        end
        if (done_o === 1'b1) begin
            check_output("done_expected", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0)
                check_output("rdata_at_done", rdata_o, sb_q.pop_front());
        end
    end

    task automatic wait_done(output int n, input bit chk_busy);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (chk_busy && done_o !== 1'b1)
                check_output("busy_while_pending", busy_o, 32'd1);
        end while (done_o !== 1'b1 && n < 40);
    endtask

    task automatic apply_stimulus(input string tag, input logic wr, input logic rd,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_load, input int exp_lat,
                                  input int exp_strobes);
        int base;
        int lat;
        @(negedge clk);
        mem_write_i = wr;
        mem_read_i  = rd;
        addr_i      = addr;
        addr_high_i = addr[13:8];
        wdata_i     = wdata;
        if (!wr)
            model_rdata = exp_load;
        sb_q.push_back(model_rdata);
        base = strobe_total;
        @(posedge clk);
        #1;
        check_output({tag, "_busy_accept"}, busy_o, 32'd1);
        @(negedge clk);
        mem_write_i = 1'b0;
        mem_read_i  = 1'b0;
        wait_done(lat, 1'b1);
        check_output({tag, "_latency"}, lat, exp_lat);
        check_output({tag, "_busy_at_done"}, busy_o, 32'd0);
        check_output({tag, "_strobes"}, strobe_total - base, exp_strobes);
        @(posedge clk);
        #1;
        check_output({tag, "_done_one_cycle"}, done_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        int base;
        rst_n       = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        addr_i      = '0;
        addr_high_i = '0;
        wdata_i     = '0;
        switch_i    = '0;
        model_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_rdata", rdata_o, 32'd0);
        check_output("rst_busy", busy_o, 32'd0);
        check_output("rst_done", done_o, 32'd0);
        check_output("rst_ram_en", ram_en_o, 32'd0);
        check_output("rst_ram_we", ram_we_o, 32'd0);
        check_output("rst_ram_addr", ram_addr_o, 32'd0);
        check_output("rst_ram_wdata", ram_wdata_o, 32'd0);
        check_output("rst_led", led_o, 32'd0);
`ifdef ALIGN_CHECK_EN
        check_output("rst_misalign", misalign_o, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus("st10", 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, MEM_LATENCY + 1, 1);
        check_output("st10_addr", last_addr, 32'd4);
        check_output("st10_we", last_we, 32'd1);
        check_output("st10_wdata", last_wdata, 32'hDEAD_BEEF);
        apply_stimulus("st20", 1, 0, 32'h0000_0020, 32'h1234_5678, 32'h0, MEM_LATENCY + 1, 1);
        apply_stimulus("ld10", 0, 1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, MEM_LATENCY + 1, 1);
        check_output("ld10_we", last_we, 32'd0);
        apply_stimulus("ld20", 0, 1, 32'h0000_0020, 32'h0, 32'h1234_5678, MEM_LATENCY + 1, 1);
        apply_stimulus("ldwrap", 0, 1, 32'h0001_0020, 32'h0, 32'h1234_5678, MEM_LATENCY + 1, 1);
        check_output("ldwrap_addr", last_addr, 32'd8);
`ifndef ALIGN_CHECK_EN
        apply_stimulus("ldlow", 0, 1, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, MEM_LATENCY + 1, 1);
        check_output("ldlow_addr", last_addr, 32'd4);
`endif

        apply_stimulus("ioled_st", 1, 0, 32'hFFFF_FC00, 32'h1234_A5A5, 32'h0, 1, 0);
        check_output("led_after_store", led_o, 32'h0000_A5A5);
        switch_i = 16'h00F0;
        apply_stimulus("iosw_ld", 0, 1, 32'hFFFF_FC10, 32'h0, 32'h0000_00F0, 1, 0);
        apply_stimulus("ioled_ld", 0, 1, 32'hFFFF_FC00, 32'h0, 32'h0000_A5A5, 1, 0);
        apply_stimulus("iosw_st", 1, 0, 32'hFFFF_FC10, 32'h0000_1111, 32'h0, 1, 0);
        apply_stimulus("iohole_st", 1, 0, 32'hFFFF_FC30, 32'h0000_2222, 32'h0, 1, 0);
        check_output("led_ignored_stores", led_o, 32'h0000_A5A5);
        apply_stimulus("iohole_ld", 0, 1, 32'hFFFF_FC20, 32'h0, 32'h0, 1, 0);

        apply_stimulus("rw_both", 1, 1, 32'h0000_0030, 32'hCAFE_F00D, 32'h0, MEM_LATENCY + 1, 1);
        check_output("rw_both_we", last_we, 32'd1);
        check_output("rw_both_addr", last_addr, 32'd12);
        apply_stimulus("ld30", 0, 1, 32'h0000_0030, 32'h0, 32'hCAFE_F00D, MEM_LATENCY + 1, 1);

        // Request held high across two accesses: the second is accepted only after DONE.
        @(negedge clk);
        mem_read_i  = 1'b1;
        addr_i      = 32'h0000_0020;
        addr_high_i = 6'h00;
        model_rdata = 32'h1234_5678;
        sb_q.push_back(model_rdata);
        sb_q.push_back(model_rdata);
        base = strobe_total;
        wait_done(n, 1'b0);
        check_output("hold_ram_first", n, MEM_LATENCY + 2);
        wait_done(n, 1'b0);
        check_output("hold_ram_spacing", n, MEM_LATENCY + 3);
        @(negedge clk);
        mem_read_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("hold_ram_idle", busy_o, 32'd0);
        check_output("hold_ram_strobes", strobe_total - base, 32'd2);

        @(negedge clk);
        mem_read_i  = 1'b1;
        addr_i      = 32'hFFFF_FC10;
        addr_high_i = 6'h3C;
        model_rdata = 32'h0000_00F0;
        sb_q.push_back(model_rdata);
        sb_q.push_back(model_rdata);
        wait_done(n, 1'b0);
        check_output("hold_io_first", n, 32'd2);
        wait_done(n, 1'b0);
        check_output("hold_io_spacing", n, 32'd3);
        @(negedge clk);
        mem_read_i = 1'b0;
        repeat (2) @(posedge clk);

        // Reset asserted one edge into a RAM load abandons it.
        @(negedge clk);
        mem_read_i  = 1'b1;
        addr_i      = 32'h0000_0010;
        addr_high_i = 6'h00;
        @(posedge clk);
        #1;
        check_output("rstmid_busy_accept", busy_o, 32'd1);
        @(negedge clk);
        rst_n      = 1'b0;
        mem_read_i = 1'b0;
        @(posedge clk);
        #1;
        check_output("rstmid_busy", busy_o, 32'd0);
        check_output("rstmid_rdata", rdata_o, 32'd0);
        check_output("rstmid_led", led_o, 32'd0);
        check_output("rstmid_ram_en", ram_en_o, 32'd0);
        check_output("rstmid_done", done_o, 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        model_rdata = 32'h0;
        repeat (MEM_LATENCY + 4) @(posedge clk);
        #1;
        check_output("rstmid_idle", busy_o, 32'd0);
        apply_stimulus("rstmid_led_ld", 0, 1, 32'hFFFF_FC00, 32'h0, 32'h0, 1, 0);

`ifdef ALIGN_CHECK_EN
        apply_stimulus("ld30_again", 0, 1, 32'h0000_0030, 32'h0, 32'hCAFE_F00D, MEM_LATENCY + 1, 1);
        check_output("pre_misalign", misalign_o, 32'd0);
        apply_stimulus("misal_ld", 0, 1, 32'h0000_0013, 32'h0, 32'hCAFE_F00D, 1, 0);
        check_output("misalign_set", misalign_o, 32'd1);
        switch_i = 16'h0055;
        apply_stimulus("misal_io", 0, 1, 32'hFFFF_FC13, 32'h0, 32'h0000_0055, 1, 0);
        check_output("misalign_sticky", misalign_o, 32'd1);
`endif

        check_output("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
